// File: rtl/hier_node_ctrl.sv
// hier_node_ctrl: hierarchy node controller. One parent start fans out to the
// selected children (all at once or one at a time in index order), and their
// completions are joined into a single done pulse with cycle count, live
// pending set and a per-launch timeout flag.
//
// Handshake: start_i is a level sampled only in IDLE; the cycle it is seen
// there is the accept cycle. There is no ready signal: busy_o=1 means any
// start_i is dropped (never queued). child_start_o / child_done_i / done_o are
// single-cycle pulses; a child_done_i bit counts only while the FSM is in WAIT
// and that child is outstanding.
module hier_node_ctrl #(
  parameter int NUM_CHILDREN = 5,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT_CYC  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_i,
  input  logic                    mode_i,
  input  logic [NUM_CHILDREN-1:0] child_mask_i,
  output logic [NUM_CHILDREN-1:0] child_start_o,
  input  logic [NUM_CHILDREN-1:0] child_done_i,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic [CNT_W-1:0]        cycles_o,
  output logic [NUM_CHILDREN-1:0] pending_o,
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  // wait counter only needs to count 0 .. TIMEOUT_CYC-1
  localparam int WT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t                  state_q, state_n;
  logic [NUM_CHILDREN-1:0] pend_q, pend_n;
  logic [NUM_CHILDREN-1:0] outstanding, hit, launch_vec;
  logic                    mode_q, launch_mode, to_err;
  logic [CNT_W-1:0]        run_q, run_inc;
  logic [WT_W-1:0]         wait_q;
  logic                    timeout_hit;

  // isolate the lowest set bit (sequential mode launches in index order)
  function automatic logic [NUM_CHILDREN-1:0] lowest(input logic [NUM_CHILDREN-1:0] v);
    return v & (~v + NUM_CHILDREN'(1));
  endfunction

  // in sequential mode only the child currently launched may complete; since
  // pending only ever loses that child, it is always the lowest pending bit
  assign outstanding = mode_q ? lowest(pend_q) : pend_q;
  assign hit         = child_done_i & outstanding;
  assign run_inc     = (&run_q) ? run_q : run_q + CNT_W'(1);
  assign timeout_hit = (TIMEOUT_CYC > 0) && (wait_q == WT_W'(TIMEOUT_CYC - 1));
  assign launch_vec  = launch_mode ? lowest(pend_n) : pend_n;
  assign pending_o   = pend_q;
  assign dbg_state   = state_q;

  // next-state, next pending set and timeout decision
  always_comb begin
    state_n     = state_q;
    pend_n      = pend_q;
    launch_mode = mode_q;
    to_err      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pend_n      = child_mask_i;
          launch_mode = mode_i;
          state_n     = (child_mask_i == '0) ? S_DONE : S_LAUNCH;
        end
      end
      S_LAUNCH: state_n = S_WAIT;
      S_WAIT: begin
        pend_n = pend_q & ~hit;
        // completion wins over a timeout reached in the same cycle
        if (pend_n == '0) begin
          state_n = S_DONE;
        end else if (mode_q && (hit != '0)) begin
          state_n = S_LAUNCH;
        end else if (timeout_hit) begin
          state_n = S_DONE;
          to_err  = 1'b1;
        end
      end
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // state, counters and registered outputs (outputs follow the next state so
  // they line up with the cycle the FSM is in that state)
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      pend_q        <= '0;
      mode_q        <= 1'b0;
      run_q         <= '0;
      wait_q        <= '0;
      child_start_o <= '0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      err_o         <= 1'b0;
      cycles_o      <= '0;
    end else begin
      state_q       <= state_n;
      pend_q        <= pend_n;
      child_start_o <= (state_n == S_LAUNCH) ? launch_vec : '0;
      busy_o        <= (state_n != S_IDLE);
      done_o        <= (state_n == S_DONE);
      // run_q holds the index of the current cycle counted from the accept
      if (state_q == S_IDLE && start_i) begin
        mode_q <= mode_i;
        err_o  <= 1'b0;
        run_q  <= CNT_W'(1);
      end else if (state_q != S_IDLE) begin
        run_q <= run_inc;
      end
      if (to_err) err_o <= 1'b1;
      if (state_n == S_DONE) cycles_o <= (state_q == S_IDLE) ? CNT_W'(1) : run_inc;
      if (state_n == S_LAUNCH)     wait_q <= '0;
      else if (state_q == S_WAIT) wait_q <= wait_q + WT_W'(1);
    end
  end

endmodule

// File: tb/tb_hier_node_ctrl.sv
// Bench for hier_node_ctrl (5 children, 8-cycle timeout). Each run's expected
// waveform is computed per relative cycle from the timing rules: launch cycles,
// first valid completion of each child inside its window, done cycle.
module tb_hier_node_ctrl;

  localparam int N = 5;
  localparam int T = 8;
  localparam int W = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         start_i = 1'b0, mode_i = 1'b0;
  logic [N-1:0] child_mask_i = '0, child_done_i = '0;
  logic [N-1:0] child_start_o, pending_o;
  logic         busy_o, done_o, err_o;
  logic [W-1:0] cycles_o;
  logic [1:0]   dbg_state;

  hier_node_ctrl #(.NUM_CHILDREN(N), .CNT_W(W), .TIMEOUT_CYC(T)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .mode_i(mode_i),
    .child_mask_i(child_mask_i), .child_start_o(child_start_o),
    .child_done_i(child_done_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .cycles_o(cycles_o), .pending_o(pending_o),
    .dbg_state(dbg_state)
  );

  // expected waveform of the current run, indexed by cycle since accept
  logic [N-1:0] dn_tab[64];
  logic [N-1:0] exp_start[64], exp_pend[64];
  logic         exp_done[64], exp_busy[64], exp_err[64];
  logic [W-1:0] exp_cyc[64];
  logic [N-1:0] prev_pend = '0;
  logic         prev_err = 1'b0;
  logic [W-1:0] prev_cyc = '0;
  int           run_len;
  int           rel = 0;
  bit           chk_en = 1'b0;
  int           n_chk = 0, n_pass = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s rel_cycle=%0d got=%0h expected=%0h", nm, rel, act, exp);
  endtask

  // behavioural model: one run of the node as a timeline
  task automatic model(input bit md, input logic [N-1:0] mk, input int rst_at,
                       input int exp_d);
    int fin_t[N];
    int d, l, fin;
    bit e;
    d = 0; e = 1'b0;
    for (int i = 0; i < N; i++) fin_t[i] = -1;
    for (int c = 0; c < 64; c++) begin
      exp_start[c] = '0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0;
    end
    if (mk == '0) begin
      d = 1;
    end else if (!md) begin
      exp_start[1] = mk;
      for (int i = 0; i < N; i++) begin
        if (mk[i]) begin
          fin = -1;
          for (int k = 2; k <= 1 + T; k++) if (fin < 0 && dn_tab[k][i]) fin = k;
          fin_t[i] = fin;
          if (fin < 0) e = 1'b1;
          else if (fin + 1 > d) d = fin + 1;
        end
      end
      if (e) d = T + 2;
    end else begin
      l = 1;
      for (int i = 0; i < N; i++) begin
        if (mk[i] && d == 0) begin
          exp_start[l] = N'(1) << i;
          fin = -1;
          for (int k = l + 1; k <= l + T; k++) if (fin < 0 && dn_tab[k][i]) fin = k;
          fin_t[i] = fin;
          if (fin < 0) begin e = 1'b1; d = l + T + 1; end
          else l = fin + 1;
        end
      end
      if (d == 0) d = l;
    end
    chk("model_done_cycle", 32'(d), 32'(exp_d));
    for (int c = 0; c < 64; c++) begin
      exp_busy[c] = (c >= 1 && c <= d);
      exp_done[c] = (c == d);
      exp_cyc[c]  = (c < d) ? prev_cyc : W'(d);
      exp_err[c]  = (c == 0) ? prev_err : ((c >= d) ? e : 1'b0);
      if (c == 0) exp_pend[c] = prev_pend;
      else for (int i = 0; i < N; i++)
        exp_pend[c][i] = mk[i] && (fin_t[i] < 0 || c <= fin_t[i]);
      if (rst_at > 0 && c > rst_at) begin
        exp_start[c] = '0; exp_done[c] = 1'b0; exp_busy[c] = 1'b0;
        exp_err[c] = 1'b0; exp_cyc[c] = '0; exp_pend[c] = '0;
      end
    end
    if (rst_at > 0) begin
      run_len = rst_at + 3;
      prev_pend = '0; prev_err = 1'b0; prev_cyc = '0;
    end else begin
      run_len = d;
      prev_pend = exp_pend[d]; prev_err = e; prev_cyc = W'(d);
    end
  endtask

  // driver: one run, cycle 0 is the accept cycle
  task automatic run_scn(input bit md, input logic [N-1:0] mk, input bit hold,
                         input int rst_at, input int exp_d);
    model(md, mk, rst_at, exp_d);
    for (int c = 0; c <= run_len; c++) begin
      start_i      = (c == 0) || (hold && (rst_at == 0 || c <= rst_at));
      rst          = (rst_at > 0 && c == rst_at);
      mode_i       = (c == 0) ? md : 1'($urandom_range(1, 0));
      child_mask_i = (c == 0) ? mk : N'($urandom_range(31, 0));
      child_done_i = dn_tab[c];
      rel          = c;
      chk_en       = 1'b1;
      @(posedge clk); #1;
    end
    chk_en = 1'b0; start_i = 1'b0; rst = 1'b0; child_done_i = '0;
  endtask

  task automatic clr_dn();
    for (int c = 0; c < 64; c++) dn_tab[c] = '0;
  endtask

  // scoreboard compare: every cycle of a run
  always @(negedge clk) begin
    if (chk_en) begin
      chk("child_start", 32'(child_start_o), 32'(exp_start[rel]));
      chk("done",        32'(done_o),        32'(exp_done[rel]));
      chk("busy",        32'(busy_o),        32'(exp_busy[rel]));
      chk("err",         32'(err_o),         32'(exp_err[rel]));
      chk("cycles",      32'(cycles_o),      32'(exp_cyc[rel]));
      chk("pending",     32'(pending_o),     32'(exp_pend[rel]));
    end
  end

  initial begin
    clr_dn();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // parallel, all five done together at cycle 4
    clr_dn(); dn_tab[4] = 5'b11111;
    run_scn(1'b0, 5'b11111, 1'b0, 0, 5);
    // sequential, children 2 then 4
    clr_dn(); dn_tab[3] = 5'b00100; dn_tab[6] = 5'b10000;
    run_scn(1'b1, 5'b10100, 1'b0, 0, 7);
    // parallel timeout, child 0 silent
    clr_dn();
    run_scn(1'b0, 5'b00001, 1'b0, 0, 10);
    // spurious: child 0 during LAUNCH, child 4 outside mask
    clr_dn(); dn_tab[1] = 5'b00001; dn_tab[3] = 5'b10000;
    dn_tab[4] = 5'b00001; dn_tab[6] = 5'b00010;
    run_scn(1'b0, 5'b00011, 1'b0, 0, 7);
    // start held through a sequential run; re-accept right after
    clr_dn(); dn_tab[2] = 5'b00001; dn_tab[5] = 5'b00010;
    run_scn(1'b1, 5'b00011, 1'b1, 0, 6);
    // completion in the very cycle the timeout is reached
    clr_dn(); dn_tab[9] = 5'b01010;
    run_scn(1'b0, 5'b01010, 1'b0, 0, 10);
    // empty mask
    clr_dn();
    run_scn(1'b0, 5'b00000, 1'b0, 0, 1);
    // sequential timeout on the second child
    clr_dn(); dn_tab[3] = 5'b00010;
    run_scn(1'b1, 5'b00110, 1'b0, 0, 13);
    // reset in cycle 3 of a parallel run, late completions afterwards
    clr_dn(); dn_tab[5] = 5'b11111;
    run_scn(1'b0, 5'b11111, 1'b0, 3, 6);
    // minimum-length run after reset
    clr_dn(); dn_tab[2] = 5'b00100;
    run_scn(1'b0, 5'b00100, 1'b0, 0, 3);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
